acq_controller: RTL and testbench
=================================

Name: acq_controller

Overview:
- Sequences one oscilloscope acquisition frame: timebase, pre-trigger fill, trigger search, post-trigger fill, and hand-off to the display reader.
- Generates a single-clock sample-enable strobe at 1/1, 1/2, 1/4 or 1/8 of clk_in, selected by time_div. No derived clocks.
- Drives the write port of the circular sample RAM.
- Sits between the ADC capture register and the sample buffer / display readout.

Parameters:
- DW, 8, ADC sample width.
- AW, 9, sample buffer address width; DEPTH = 2^AW.
- PRE, 128, pre-trigger samples per frame; legal range 1..DEPTH-2.
- AUTO_TO, 4096, ARM-state samples without a trigger before a forced trigger; 0 disables auto trigger.

Ports:
- clk_in  in  1  system clock
- rst  in  1  synchronous, active-high reset
- time_div  in  2  timebase select; sample period = 2^time_div clk_in cycles
- run  in  1  level; continuous acquisition
- single  in  1  one-cycle pulse; one frame
- abort  in  1  one-cycle pulse; cancel acquisition
- trig_level  in  DW  trigger threshold, unsigned
- trig_slope  in  1  0 = rising, 1 = falling
- adc_data  in  DW  current ADC sample
- wr_en  out  1  sample RAM write strobe
- wr_addr  out  AW  sample RAM write address
- wr_data  out  DW  sample RAM write data
- trig_addr  out  AW  address of the trigger sample
- start_addr  out  AW  oldest frame sample = trig_addr - PRE, mod DEPTH
- auto_trig  out  1  last frame was force-triggered
- busy  out  1  high in PRE, ARM and POST
- frame_ready  out  1  frame complete, level
- frame_ack  in  1  one-cycle pulse from reader

Behaviour:
- Reset: state IDLE. All outputs 0. Pointer, divider and counters 0. Reset applies mid-frame with no write completion.
- States:
  - IDLE -> PRE: on run=1 or single=1. On entry, latch time_div into tdl, clear div_cnt, ptr and sample counters. time_div changes while not in IDLE are ignored until the next entry.
  - Tick: div_cnt increments every cycle in PRE/ARM/POST and wraps at 2^tdl-1. tick=1 when div_cnt==2^tdl-1. With tdl=0, tick fires every cycle starting with the first PRE cycle.
  - Capture: on each tick, adc_data is captured. The next cycle has wr_en=1, wr_addr=ptr, wr_data=captured sample, then ptr increments mod DEPTH. Write latency is 1 cycle. wr_en is a one-cycle pulse per tick.
  - PRE: after PRE ticks -> ARM.
  - ARM: each tick compares prev (the previous captured sample; for the first ARM tick, the last PRE sample) against cur.
    - Rising trigger: prev < trig_level and cur >= trig_level.
    - Falling trigger: prev > trig_level and cur <= trig_level.
    - On trigger: trig_addr = address of cur; auto_trig = 0; -> POST.
    - If AUTO_TO != 0 and the ARM tick count reaches AUTO_TO: force trigger on that tick; auto_trig = 1.
  - POST: captures DEPTH-PRE-1 further samples. The cycle after the final wr_en: -> HOLD, frame_ready = 1, start_addr valid.
  - HOLD: no writes; div_cnt frozen. frame_ack while frame_ready=1: frame_ready = 0 next cycle; -> PRE (re-latch time_div) if run=1, else -> IDLE. frame_ack in any other state is ignored.
- Priorities:
  - rst > abort > all else.
  - abort in PRE/ARM/POST/HOLD: -> IDLE next cycle. frame_ready cleared, no further wr_en. trig_addr and auto_trig retain their values.
  - run and single together: run governs.
  - single while busy: ignored.
  - run dropping mid-frame: the frame completes; IDLE follows the ack.
- Boundaries:
  - ptr wraps DEPTH-1 -> 0 with no gap.
  - start_addr uses modulo subtraction.
  - Trigger on the very first ARM tick is legal.
  - Equality with trig_level counts as crossing on the cur side only.

Decomposition:
- Shared package osc_pkg holds:
  - acq_state_t enum: IDLE, PRE, ARM, POST, HOLD.
  - Slope constants SLOPE_RISE=0 and SLOPE_FALL=1.
  - Timebase width constant TDIV_W=2.
- Sub-module acq_timebase holds div_cnt, the tdl latch and tick generation, as a clock-enable generator. It is reused by the display sweep logic.

Test Plan (AW=4, DEPTH=16, PRE=4, AUTO_TO=20, DW=8):
- time_div=0, single, adc ramp 0,1,2..., level=10, rising:
  - first tick on the first PRE cycle; trigger on sample 10.
  - trig_addr=10, start_addr=6, 11 post writes, frame_ready after the last write.
- time_div=2:
  - wr_en exactly every 4 cycles.
  - changing time_div to 0 mid-ARM has no effect until the next frame.
- Falling slope, level=0x80, adc 0xFF then 0x80 on the 2nd ARM tick:
  - triggers on that tick; a sample equal to the level preceded by 0x81 also triggers.
- Constant adc=0x10, level=0x80:
  - forced trigger on the 20th ARM tick; auto_trig=1.
- run=1:
  - frame_ack causes immediate PRE with re-latched time_div.
  - frame_ack while not HOLD is ignored.
  - frame_ready stays high for 50 cycles with no ack and no writes occur.
- abort mid-POST, and rst mid-ARM:
  - next cycle IDLE, busy=0, no wr_en.
  - after rst all outputs are 0.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared definitions for the oscilloscope acquisition path: the frame
// sequencer states, trigger slope encoding and timebase select width.
package osc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_ARM,
      ST_POST,
      ST_HOLD
   } acq_state_t;

   localparam logic SLOPE_RISE = 1'b0;
   localparam logic SLOPE_FALL = 1'b1;

   // time_div selects a sample period of 2^time_div clocks
   localparam int TDIV_W = 2;

endpackage

// File: rtl/acq_timebase.sv
// Sample-rate clock-enable generator. Latches the timebase select on load
// and emits a one-cycle tick every 2^tdl enabled cycles; the divider holds
// its value while disabled. Also used by the display sweep logic.
module acq_timebase
   import osc_pkg::*;
(
   input  logic              clk_in,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_en,
   input  logic [TDIV_W-1:0] i_tdiv,
   output logic              o_tick
);

   localparam int CNT_W = (2 ** TDIV_W) - 1;

   logic [TDIV_W-1:0] r_tdl;
   logic [CNT_W-1:0]  r_div_cnt;
   logic [CNT_W-1:0]  w_top;

   assign w_top  = CNT_W'((32'd1 << r_tdl) - 32'd1);
   assign o_tick = i_en && (r_div_cnt == w_top);

   // Latch the divide ratio on frame entry and run the divider while enabled
   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_tdl     <= '0;
         r_div_cnt <= '0;
      end else if (i_load) begin
         r_tdl     <= i_tdiv;
         r_div_cnt <= '0;
      end else if (i_en) begin
         if (r_div_cnt == w_top) begin
            r_div_cnt <= '0;
         end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/acq_controller.sv
// Oscilloscope frame sequencer: pre-trigger fill, trigger search with
// optional auto trigger, post-trigger fill and hand-off to the display
// reader. Writes one sample per timebase tick into the circular sample RAM.
module acq_controller
   import osc_pkg::*;
#(
   parameter int DW      = 8,
   parameter int AW      = 9,
   parameter int PRE     = 128,
   parameter int AUTO_TO = 4096
)(
   input  logic              clk_in,
   input  logic              rst,
   input  logic [TDIV_W-1:0] time_div,
   input  logic              run,
   input  logic              single,
   input  logic              abort,
   input  logic [DW-1:0]     trig_level,
   input  logic              trig_slope,
   input  logic [DW-1:0]     adc_data,
   output logic              wr_en,
   output logic [AW-1:0]     wr_addr,
   output logic [DW-1:0]     wr_data,
   output logic [AW-1:0]     trig_addr,
   output logic [AW-1:0]     start_addr,
   output logic              auto_trig,
   output logic              busy,
   output logic              frame_ready,
   input  logic              frame_ack
);

   localparam int DEPTH = 2 ** AW;
   localparam int CW    = 32;

   acq_state_t    r_state;
   logic [AW-1:0] r_ptr;
   logic [CW-1:0] r_cnt;
   logic          r_last;
   logic [DW-1:0] r_prev;
   logic          r_wr_en;
   logic [AW-1:0] r_wr_addr;
   logic [DW-1:0] r_wr_data;
   logic [AW-1:0] r_trig_addr;
   logic [AW-1:0] r_start_addr;
   logic          r_auto_trig;
   logic          r_frame_ready;

   logic w_active;
   logic w_load;
   logic w_tick;
   logic w_cap;
   logic w_hit;
   logic w_force;

   // Threshold crossing; equality counts only on the current-sample side
   function automatic logic trig_hit(input logic [DW-1:0] prev,
                                     input logic [DW-1:0] cur,
                                     input logic [DW-1:0] level,
                                     input logic          slope);
      if (slope == SLOPE_FALL) begin
         return (prev > level) && (cur <= level);
      end
      return (prev < level) && (cur >= level);
   endfunction

   assign w_active = (r_state == ST_PRE) || (r_state == ST_ARM) || (r_state == ST_POST);

   // A new frame starts from IDLE, or straight from HOLD when run is still set
   assign w_load = !abort &&
                   (((r_state == ST_IDLE) && (run || single)) ||
                    ((r_state == ST_HOLD) && frame_ack && r_frame_ready && run));

   // Once the last post-trigger sample is taken, further ticks are dropped
   assign w_cap   = w_tick && !((r_state == ST_POST) && r_last);
   assign w_hit   = trig_hit(r_prev, adc_data, trig_level, trig_slope);
   assign w_force = (AUTO_TO != 0) && (r_cnt == CW'(AUTO_TO - 1));

   acq_timebase u_timebase (
      .clk_in (clk_in),
      .rst    (rst),
      .i_load (w_load),
      .i_en   (w_active),
      .i_tdiv (time_div),
      .o_tick (w_tick)
   );

   // Frame sequencer with registered RAM write port and frame results
   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_ptr         <= '0;
         r_cnt         <= '0;
         r_last        <= 1'b0;
         r_prev        <= '0;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_trig_addr   <= '0;
         r_start_addr  <= '0;
         r_auto_trig   <= 1'b0;
         r_frame_ready <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_cap && !abort) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_ptr;
            r_wr_data <= adc_data;
            r_prev    <= adc_data;
            r_ptr     <= r_ptr + AW'(1);
         end
         if (abort) begin
            r_state       <= ST_IDLE;
            r_frame_ready <= 1'b0;
            r_last        <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (run || single) begin
                     r_state <= ST_PRE;
                     r_ptr   <= '0;
                     r_cnt   <= '0;
                     r_last  <= 1'b0;
                  end
               end
               ST_PRE: begin
                  if (w_cap) begin
                     if (r_cnt == CW'(PRE - 1)) begin
                        r_state <= ST_ARM;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= r_cnt + CW'(1);
                     end
                  end
               end
               ST_ARM: begin
                  if (w_cap) begin
                     if (w_hit || w_force) begin
                        r_state      <= ST_POST;
                        r_cnt        <= '0;
                        r_trig_addr  <= r_ptr;
                        r_start_addr <= r_ptr - AW'(PRE);
                        r_auto_trig  <= !w_hit;
                     end else begin
                        r_cnt <= r_cnt + CW'(1);
                     end
                  end
               end
               ST_POST: begin
                  if (r_last) begin
                     r_state       <= ST_HOLD;
                     r_frame_ready <= 1'b1;
                     r_last        <= 1'b0;
                  end else if (w_cap) begin
                     if (r_cnt == CW'(DEPTH - PRE - 2)) begin
                        r_last <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt + CW'(1);
                     end
                  end
               end
               ST_HOLD: begin
                  if (frame_ack && r_frame_ready) begin
                     r_frame_ready <= 1'b0;
                     if (run) begin
                        r_state <= ST_PRE;
                        r_ptr   <= '0;
                        r_cnt   <= '0;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign wr_en       = r_wr_en;
   assign wr_addr     = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign trig_addr   = r_trig_addr;
   assign start_addr  = r_start_addr;
   assign auto_trig   = r_auto_trig;
   assign busy        = w_active;
   assign frame_ready = r_frame_ready;

endmodule

// File: tb/tb_acq_controller.sv
// Bench for acq_controller (AW=4, PRE=4, AUTO_TO=20). Expected RAM writes
// are queued when a frame is launched; a negedge monitor pops and compares
// each write and the spacing between writes.
module tb_acq_controller;

   localparam int DW      = 8;
   localparam int AW      = 4;
   localparam int PRE     = 4;
   localparam int AUTO_TO = 20;

   logic          clk_in = 1'b0;
   logic          rst;
   logic [1:0]    time_div;
   logic          run, single, abort, trig_slope, frame_ack;
   logic [DW-1:0] trig_level, adc_data, adc_val;
   logic          wr_en, auto_trig, busy, frame_ready;
   logic [AW-1:0] wr_addr, trig_addr, start_addr;
   logic [DW-1:0] wr_data;

   int cyc = 0;
   int ramp_base = 0;
   bit ramp_on = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [AW+DW-1:0] exp_q[$];
   int exp_gap = 1;
   bit gap_valid = 1'b0;
   int last_wr_cyc = 0;
   int wr_count = 0;
   int wr_snap;

   acq_controller #(.DW(DW), .AW(AW), .PRE(PRE), .AUTO_TO(AUTO_TO)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .time_div    (time_div),
      .run         (run),
      .single      (single),
      .abort       (abort),
      .trig_level  (trig_level),
      .trig_slope  (trig_slope),
      .adc_data    (adc_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .trig_addr   (trig_addr),
      .start_addr  (start_addr),
      .auto_trig   (auto_trig),
      .busy        (busy),
      .frame_ready (frame_ready),
      .frame_ack   (frame_ack)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // ramp: first cycle after launch carries 0, then 1, 2, ...
   assign adc_data = ramp_on ? DW'(cyc - ramp_base) : adc_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic push(input int idx, input logic [DW-1:0] d);
      exp_q.push_back({AW'(idx), d});
   endtask

   task automatic check_frame(input string tag, input int taddr, input int saddr, input bit at);
      check({tag, "_ready"}, frame_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_trig_addr"}, trig_addr, taddr);
      check({tag, "_start_addr"}, start_addr, saddr);
      check({tag, "_auto_trig"}, auto_trig, at);
      check({tag, "_writes_left"}, exp_q.size(), 0);
   endtask

   task automatic new_frame(input int gap);
      exp_gap   = gap;
      gap_valid = 1'b0;
   endtask

   // Write monitor: every wr_en must match the next queued write
   always @(negedge clk_in) begin : mon
      logic [AW+DW-1:0] e;
      if (wr_en === 1'b1) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr_data", {wr_addr, wr_data}, e);
         end
         if (gap_valid) check("wr_gap", cyc - last_wr_cyc, exp_gap);
         last_wr_cyc = cyc;
         gap_valid   = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; run = 1'b0; single = 1'b0; abort = 1'b0; frame_ack = 1'b0;
      time_div = 2'd0; trig_level = '0; trig_slope = 1'b0; adc_val = '0;
      repeat (3) @(posedge clk_in);
      #1;
      rst = 1'b0;
      check("reset_outputs", {wr_en, wr_addr, wr_data, trig_addr, start_addr, auto_trig, busy, frame_ready}, 0);
      step(1);

      // 1: single, 1/1 timebase, ramp, rising at 10
      time_div = 2'd0; trig_level = 8'd10; trig_slope = 1'b0;
      ramp_base = cyc + 1; ramp_on = 1'b1;
      for (int i = 0; i < 22; i++) push(i, DW'(i));
      new_frame(1);
      single = 1'b1;
      step(1);
      single = 1'b0;
      check("t1_busy_pre", busy, 1);
      step(22);
      check("t1_ready_early", frame_ready, 0);
      step(1);
      check_frame("t1", 10, 6, 0);
      frame_ack = 1'b1;
      step(1);
      frame_ack = 1'b0;
      check("t1_ack_clear", frame_ready, 0);
      check("t1_idle", busy, 0);

      // 2: 1/4 timebase, time_div changed to 0 mid-ARM
      time_div = 2'd2; trig_level = 8'd30; trig_slope = 1'b0;
      ramp_base = cyc + 1; ramp_on = 1'b1;
      for (int k = 0; k < 19; k++) push(k, DW'(4 * k + 3));
      new_frame(4);
      single = 1'b1;
      step(1);
      single = 1'b0;
      step(21);
      time_div = 2'd0;
      step(55);
      check("t2_ready_early", frame_ready, 0);
      step(1);
      check_frame("t2", 7, 3, 0);
      frame_ack = 1'b1;
      step(1);
      frame_ack = 1'b0;
      ramp_on = 1'b0;

      // 3: falling at 0x80, 0xFF then 0x80 on second ARM tick
      time_div = 2'd0; trig_level = 8'h80; trig_slope = 1'b1; adc_val = 8'hFF;
      for (int i = 0; i < 5; i++) push(i, 8'hFF);
      for (int i = 5; i < 17; i++) push(i, 8'h80);
      new_frame(1);
      single = 1'b1;
      step(1);
      single = 1'b0;
      step(5);
      adc_val = 8'h80;
      step(12);
      check("t3_ready_early", frame_ready, 0);
      step(1);
      check_frame("t3", 5, 1, 0);
      frame_ack = 1'b1;
      step(1);
      frame_ack = 1'b0;

      // 4: run with single, 0x81 -> 0x80 on first ARM tick, ack during PRE
      adc_val = 8'h81;
      for (int i = 0; i < 4; i++) push(i, 8'h81);
      for (int i = 4; i < 16; i++) push(i, 8'h80);
      new_frame(1);
      run = 1'b1; single = 1'b1;
      step(1);
      single = 1'b0; frame_ack = 1'b1;
      step(1);
      frame_ack = 1'b0;
      step(3);
      adc_val = 8'h80;
      step(12);
      check("t4_ready_early", frame_ready, 0);
      step(1);
      check_frame("t4", 4, 0, 0);
      wr_snap = wr_count;
      step(50);
      check("t4_hold_ready", frame_ready, 1);
      check("t4_hold_busy", busy, 0);
      check("t4_hold_no_writes", wr_count, wr_snap);

      // 4b: ack in HOLD with run restarts at 1/4, constant input forces trigger
      time_div = 2'd2; trig_slope = 1'b0; adc_val = 8'h10;
      for (int i = 0; i < 35; i++) push(i, 8'h10);
      new_frame(4);
      frame_ack = 1'b1;
      step(1);
      frame_ack = 1'b0;
      check("t4b_restart_busy", busy, 1);
      check("t4b_restart_ready", frame_ready, 0);
      step(9);
      run = 1'b0;
      step(131);
      check("t4b_ready_early", frame_ready, 0);
      step(1);
      check_frame("t4b", 7, 3, 1);
      frame_ack = 1'b1;
      step(1);
      frame_ack = 1'b0;
      check("t4b_idle_after_ack", busy, 0);
      check("t4b_ready_cleared", frame_ready, 0);
      step(5);
      check("t4b_stays_idle", busy, 0);

      // 5: abort in POST
      time_div = 2'd0; trig_level = 8'd10; trig_slope = 1'b0;
      ramp_base = cyc + 1; ramp_on = 1'b1;
      for (int i = 0; i < 14; i++) push(i, DW'(i));
      new_frame(1);
      single = 1'b1;
      step(1);
      single = 1'b0;
      step(14);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("t5_abort_busy", busy, 0);
      check("t5_abort_ready", frame_ready, 0);
      check("t5_abort_trig_addr", trig_addr, 10);
      check("t5_abort_auto", auto_trig, 0);
      step(5);
      check("t5_writes_left", exp_q.size(), 0);
      ramp_on = 1'b0;

      // 6: rst in ARM
      time_div = 2'd0; trig_level = 8'h80; trig_slope = 1'b0; adc_val = 8'h10;
      for (int i = 0; i < 7; i++) push(i, 8'h10);
      new_frame(1);
      single = 1'b1;
      step(1);
      single = 1'b0;
      step(7);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("t6_rst_outputs", {wr_en, wr_addr, wr_data, trig_addr, start_addr, auto_trig, busy, frame_ready}, 0);
      step(3);
      check("t6_writes_left", exp_q.size(), 0);
      check("t6_stays_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
